// File: rtl/led_ctrl_pkg.sv
// Shared types for the LED mode controller: the mode encoding and its
// cyclic successor.
package led_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    // Mode visited after a button release; FAST wraps back to OFF.
    function automatic mode_e next_mode(input mode_e cur);
        mode_e nxt;
        case (cur)
            MODE_OFF:  nxt = MODE_ON;
            MODE_ON:   nxt = MODE_SLOW;
            MODE_SLOW: nxt = MODE_FAST;
            default:   nxt = MODE_OFF;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchronizer followed by a counting debouncer. o_stable is the
// filtered switch level; o_fall pulses for one cycle when it drops 1 -> 0.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_switch,
    output logic o_stable,
    output logic o_fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next state: count cycles of disagreement, accept the new level once it
    // has persisted long enough, and flag only the falling transition.
    always_comb begin
        sync1_d  = i_switch;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        fall_d   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                fall_d   = stable_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset clears all filtering progress.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            fall_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            fall_q   <= fall_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_stable = stable_q;
    assign o_fall   = fall_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: each debounced button release steps the mode
// OFF -> ON -> SLOW -> FAST -> OFF; SLOW and FAST blink the LED.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SLOW_DIV        = 12500000,
    parameter int FAST_DIV        = 2500000
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_switch_1,
    output logic              o_led_1,
    output logic [MODE_W-1:0] o_mode
);

    localparam int BLINK_W = $clog2(SLOW_DIV);
    localparam logic [BLINK_W-1:0] SLOW_LAST = BLINK_W'(SLOW_DIV - 1);
    localparam logic [BLINK_W-1:0] FAST_LAST = BLINK_W'(FAST_DIV - 1);

    mode_e              mode_q, mode_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               release_pulse;
    logic               stable_unused;

    // The filtered level itself is not needed here, only the release pulse.
    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .i_rst_n  (i_rst_n),
        .i_switch (i_switch_1),
        .o_stable (stable_unused),
        .o_fall   (release_pulse)
    );

    // Mode/blink next state: a release restarts the blink lit at count 0,
    // overriding any terminal count in the same cycle.
    always_comb begin
        mode_d      = mode_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (release_pulse) begin
            mode_d      = next_mode(mode_q);
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else begin
            case (mode_q)
                MODE_SLOW: begin
                    if (blink_cnt_q == SLOW_LAST) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
                MODE_FAST: begin
                    if (blink_cnt_q == FAST_LAST) begin
                        blink_cnt_d = '0;
                        phase_d     = ~phase_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
                    end
                end
                default: blink_cnt_d = '0;
            endcase
        end
    end

    // Mode and blink registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q      <= MODE_OFF;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // LED decode from registered mode and phase only, so it is glitch-free.
    always_comb begin
        o_led_1 = 1'b0;
        case (mode_q)
            MODE_ON:              o_led_1 = 1'b1;
            MODE_SLOW, MODE_FAST: o_led_1 = phase_q;
            default:              o_led_1 = 1'b0;
        endcase
    end

    assign o_mode = mode_q;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with short debounce and blink periods.
module tb_led_mode_ctrl;

    logic       clk;
    logic       rstN;
    logic       switchIn;
    logic       led;
    logic [1:0] mode;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int fallCount  = 0;

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SLOW_DIV(8),
        .FAST_DIV(2)
    ) dut (
        .clk        (clk),
        .i_rst_n    (rstN),
        .i_switch_1 (switchIn),
        .o_led_1    (led),
        .o_mode     (mode)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count release pulses seen mid-cycle.
    always @(negedge clk) begin
        if (dut.u_debounce.o_fall === 1'b1) fallCount++;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic sw, input int cycles);
        switchIn = sw;
        tick(cycles);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN     = 1'b0;
        switchIn = 1'b0;
        #1;
        checkOutput("reset_mode", 32'(mode), 32'd0);
        checkOutput("reset_led", 32'(led), 32'd0);
        tick(2);
        rstN = 1'b1;
        tick(3);
        checkOutput("idle_mode", 32'(mode), 32'd0);

        // Clean press then release: mode steps on the 7th edge.
        applyStimulus(1'b1, 20);
        checkOutput("press_no_step", 32'(mode), 32'd0);
        applyStimulus(1'b0, 6);
        checkOutput("release_edge6", 32'(mode), 32'd0);
        tick(1);
        checkOutput("release_edge7", 32'(mode), 32'd1);
        checkOutput("on_led", 32'(led), 32'd1);
        checkOutput("fall_count1", 32'(fallCount), 32'd1);

        // Short glitches in both directions are filtered out.
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 10);
        checkOutput("idle_glitch_mode", 32'(mode), 32'd1);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 3);
        applyStimulus(1'b1, 10);
        checkOutput("held_glitch_mode", 32'(mode), 32'd1);
        checkOutput("held_glitch_led", 32'(led), 32'd1);
        checkOutput("glitch_no_pulse", 32'(fallCount), 32'd1);

        // Release into SLOW: 8 lit cycles then 8 dark.
        applyStimulus(1'b0, 7);
        checkOutput("slow_mode", 32'(mode), 32'd2);
        checkOutput("slow_first_lit", 32'(led), 32'd1);
        tick(7);
        checkOutput("slow_last_lit", 32'(led), 32'd1);
        tick(1);
        checkOutput("slow_first_dark", 32'(led), 32'd0);
        tick(7);
        checkOutput("slow_last_dark", 32'(led), 32'd0);
        tick(1);
        checkOutput("slow_relit", 32'(led), 32'd1);

        // Into FAST: 2 lit, 2 dark.
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 7);
        checkOutput("fast_mode", 32'(mode), 32'd3);
        checkOutput("fast_first_lit", 32'(led), 32'd1);
        tick(1);
        checkOutput("fast_second_lit", 32'(led), 32'd1);
        tick(1);
        checkOutput("fast_first_dark", 32'(led), 32'd0);
        tick(1);
        checkOutput("fast_second_dark", 32'(led), 32'd0);
        tick(1);
        checkOutput("fast_relit", 32'(led), 32'd1);

        // Release pulse coincides with FAST terminal count: mode change wins.
        applyStimulus(1'b1, 21);
        applyStimulus(1'b0, 6);
        checkOutput("collide_pre_mode", 32'(mode), 32'd3);
        checkOutput("collide_pre_cnt", 32'(dut.blink_cnt_q), 32'd1);
        checkOutput("collide_pre_pulse", 32'(dut.u_debounce.o_fall), 32'd1);
        tick(1);
        checkOutput("collide_mode", 32'(mode), 32'd0);
        checkOutput("collide_led", 32'(led), 32'd0);
        checkOutput("collide_cnt", 32'(dut.blink_cnt_q), 32'd0);
        checkOutput("collide_phase", 32'(dut.phase_q), 32'd1);
        tick(1);
        checkOutput("off_cnt_hold", 32'(dut.blink_cnt_q), 32'd0);
        checkOutput("fall_count4", 32'(fallCount), 32'd4);

        // Back to SLOW, then reset mid-blink and mid-debounce.
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 7);
        checkOutput("cycle_on", 32'(mode), 32'd1);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 7);
        checkOutput("cycle_slow", 32'(mode), 32'd2);
        tick(3);
        checkOutput("mid_blink_led", 32'(led), 32'd1);
        applyStimulus(1'b1, 2);
        rstN = 1'b0;
        #1;
        checkOutput("async_reset_mode", 32'(mode), 32'd0);
        checkOutput("async_reset_led", 32'(led), 32'd0);
        switchIn = 1'b0;
        tick(2);
        rstN = 1'b1;
        tick(10);
        checkOutput("post_reset_mode", 32'(mode), 32'd0);
        checkOutput("post_reset_led", 32'(led), 32'd0);

        // Switch held through reset deassertion: no advance until released.
        rstN     = 1'b0;
        switchIn = 1'b1;
        tick(2);
        rstN = 1'b1;
        tick(20);
        checkOutput("held_reset_mode", 32'(mode), 32'd0);
        checkOutput("held_reset_pulses", 32'(fallCount), 32'd6);
        applyStimulus(1'b0, 6);
        checkOutput("held_release_edge6", 32'(mode), 32'd0);
        tick(1);
        checkOutput("held_release_edge7", 32'(mode), 32'd1);
        tick(20);
        checkOutput("held_release_once", 32'(mode), 32'd1);
        checkOutput("fall_count7", 32'(fallCount), 32'd7);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
